vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, hsync pulse width in pixels.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_VISIBLE, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vsync pulse width in lines.
REQ-008 SHALL have parameter V_BP, default 33, vertical back porch in lines.
REQ-009 SHALL have parameter PIX_DIV, default 4, clk cycles per pixel (≥2).
REQ-010 SHALL have port clk, input, 1, system clock; the only clock.
REQ-011 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-012 SHALL have port rgb_in, input, 12, pixel colour {R,G,B} from the pixel generator.
REQ-013 SHALL have port pclk_en, output, 1, one-clk pixel strobe.
REQ-014 SHALL have port h_cnt, output, 10, current pixel column.
REQ-015 SHALL have port v_cnt, output, 10, current line.
REQ-016 SHALL have port valid, output, 1, pixel inside the visible area.
REQ-017 SHALL have port frame_start, output, 1, one-clk pulse at each frame origin.
REQ-018 SHALL have ports hsync and vsync, output, 1 each, active-low sync.
REQ-019 SHALL have ports vgaRed, vgaGreen and vgaBlue, output, 4 each, DAC colour.

Function
REQ-020 SHALL run a divider counter 0..PIX_DIV-1, wrapping to 0; pclk_en=1 exactly when the divider equals PIX_DIV-1.
REQ-021 SHALL advance h_cnt by 1 only on clk edges where pclk_en=1.
REQ-022 SHALL define H_TOTAL=H_VISIBLE+H_FP+H_SYNC+H_BP (default 800) and V_TOTAL (default 525).
REQ-023 SHALL, on an edge with pclk_en=1 and h_cnt=H_TOTAL-1, set h_cnt to 0 and advance v_cnt.
REQ-024 SHALL, on that same edge with v_cnt=V_TOTAL-1, set v_cnt to 0; no count exceeds TOTAL-1.
REQ-025 SHALL drive valid=1 iff h_cnt<H_VISIBLE and v_cnt<V_VISIBLE, decoded from the registered counters.
REQ-026 SHALL drive hsync=0 iff H_VISIBLE+H_FP ≤ h_cnt < H_VISIBLE+H_FP+H_SYNC (default 656..751).
REQ-027 SHALL drive vsync=0 iff V_VISIBLE+V_FP ≤ v_cnt < V_VISIBLE+V_FP+V_SYNC (default 490..491).
REQ-028 SHALL assert frame_start, registered, for exactly one clk: the cycle after the edge that wraps both counters to (0,0).
REQ-029 SHALL drive {vgaRed,vgaGreen,vgaBlue}=rgb_in when the pixel is valid and 12'h000 otherwise.

Reset
REQ-030 SHALL, with rst=1 at a clk edge, set divider=0, h_cnt=0, v_cnt=0, frame_start=0 and clear any pipeline registers, regardless of counter position.
REQ-031 SHALL, after reset, produce valid=1, hsync=1, vsync=1 and pclk_en=0.
REQ-032 SHALL produce the first pclk_en PIX_DIV-1 clk after rst deasserts.

Configuration
REQ-033 SHALL, with VGA_RGB_REG_EN defined, capture rgb_in on pclk_en and delay valid, hsync and vsync by one pixel, so colour and sync leave aligned; h_cnt and v_cnt stay undelayed.
REQ-034 SHALL, without VGA_RGB_REG_EN, drive colour combinationally per REQ-029 and leave sync undelayed.

Verification
REQ-035 SHALL check: reset, then 800×525×4 clk -> exactly one frame_start, 800×525 pclk_en pulses, and counters back at (0,0).
REQ-036 SHALL check: h_cnt steps 655->656 -> hsync falls; h_cnt steps 751->752 -> hsync rises; width is 96 pixels (384 clk).
REQ-037 SHALL check: v_cnt steps 489->490 -> vsync falls; vsync low for exactly 2 lines (1600 pixels).
REQ-038 SHALL check: rgb_in=12'hF57 constant -> colour outputs R=F, G=5, B=7 at (639,479) and 0 at (640,0) and (0,480).
REQ-039 SHALL check: rst pulse at (400,300) -> next edge has h_cnt=0, v_cnt=0, frame_start=0.
REQ-040 SHALL check, with VGA_RGB_REG_EN: rgb_in steps at h_cnt=10 -> colour outputs step one pixel later, and hsync falls one pixel after h_cnt reaches 656.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-clock divider, h/v counters, sync/valid decode and colour gating.
// Define VGA_RGB_REG_EN to register colour, valid and sync so they leave the block aligned, one pixel late.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter int unsigned PIX_DIV   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] rgb_in,
  output logic        pclk_en,
  output logic [9:0]  h_cnt,
  output logic [9:0]  v_cnt,
  output logic        valid,
  output logic        frame_start,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  vgaRed,
  output logic [3:0]  vgaGreen,
  output logic [3:0]  vgaBlue
);
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(PIX_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div;
  logic             h_last, v_last;
  logic             valid_d, hsync_d, vsync_d;

  assign pclk_en = (div == DIV_MAX);
  assign h_last  = (h_cnt == H_LAST);
  assign v_last  = (v_cnt == V_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      div         <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_start <= 1'b0;
    end else begin
      div         <= pclk_en ? '0 : div + 1'b1;
      // High for the one clk following the edge that wraps both counters
      frame_start <= pclk_en && h_last && v_last;
      if (pclk_en) begin
        if (h_last) begin
          h_cnt <= '0;
          v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

  assign valid_d = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign hsync_d = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
  assign vsync_d = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));

`ifdef VGA_RGB_REG_EN
  logic [11:0] rgb_q;
  logic        valid_q, hsync_q, vsync_q;

  // Reset values match what the (0,0) position decodes to, so outputs are clean out of reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q   <= '0;
      valid_q <= 1'b1;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else if (pclk_en) begin
      rgb_q   <= rgb_in;
      valid_q <= valid_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign valid = valid_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign {vgaRed, vgaGreen, vgaBlue} = valid_q ? rgb_q : 12'h000;
`else
  assign valid = valid_d;
  assign hsync = hsync_d;
  assign vsync = vsync_d;
  assign {vgaRed, vgaGreen, vgaBlue} = valid_d ? rgb_in : 12'h000;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen at default 640x480 timing; honours VGA_RGB_REG_EN.
module tb_vga_timing_gen;
`ifdef VGA_RGB_REG_EN
  localparam int D = 1;
`else
  localparam int D = 0;
`endif
  localparam int FRAME_CLK = 800 * 525 * 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] rgb_in = 12'hF57;
  logic        pclk_en, valid, frame_start, hsync, vsync;
  logic [9:0]  h_cnt, v_cnt;
  logic [3:0]  vgaRed, vgaGreen, vgaBlue;
  logic [11:0] rgb_out;

  int checks = 0;
  int fails  = 0;

  assign rgb_out = {vgaRed, vgaGreen, vgaBlue};

  always #5 clk = ~clk;

  vga_timing_gen dut (
    .clk(clk), .rst(rst), .rgb_in(rgb_in), .pclk_en(pclk_en),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .valid(valid), .frame_start(frame_start),
    .hsync(hsync), .vsync(vsync),
    .vgaRed(vgaRed), .vgaGreen(vgaGreen), .vgaBlue(vgaBlue)
  );

  // Advance on negedges until (h,v) is reached; h<0 matches any column
  task automatic wait_hv(input int h, input int v, input string name);
    int n = 0;
    while (!(((h < 0) || (h_cnt == 10'(h))) && (v_cnt == 10'(v))) && (n < FRAME_CLK + 100)) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(((h < 0) || (h_cnt == 10'(h))) && (v_cnt == 10'(v)))) begin
      fails++;
      $display("FAIL %s: timeout at h=%0d v=%0d, wanted h=%0d v=%0d", name, h_cnt, v_cnt, h, v);
    end
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checks++;
    if (h_cnt !== 10'd0 || v_cnt !== 10'd0) begin
      fails++; $display("FAIL reset_cnt: h=%0d v=%0d, expected 0 0", h_cnt, v_cnt);
    end
    checks++;
    if ({valid, hsync, vsync, pclk_en, frame_start} !== 5'b11100) begin
      fails++;
      $display("FAIL reset_outs: valid/hs/vs/pclk/fs=%b, expected 11100",
               {valid, hsync, vsync, pclk_en, frame_start});
    end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (pclk_en !== (k == 3)) begin
        fails++; $display("FAIL first_pclk: clk %0d after reset pclk_en=%b", k, pclk_en);
      end
    end
  endtask

  task automatic test_frame();
    int np = 0;
    int nf = 0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < FRAME_CLK; i++) begin
      @(negedge clk);
      if (pclk_en) np++;
      if (frame_start) nf++;
    end
    checks++;
    if (np != 420000) begin
      fails++; $display("FAIL frame_pclk: got %0d pulses, expected 420000", np);
    end
    checks++;
    if (nf != 1) begin
      fails++; $display("FAIL frame_start_count: got %0d, expected 1", nf);
    end
    checks++;
    if (h_cnt !== 10'd0 || v_cnt !== 10'd0 || frame_start !== 1'b1) begin
      fails++;
      $display("FAIL frame_wrap: h=%0d v=%0d fs=%b, expected 0 0 1", h_cnt, v_cnt, frame_start);
    end
  endtask

  task automatic test_rgb_step();
    logic [11:0] exp10;
    exp10 = (D == 1) ? 12'hF57 : 12'hABC;
    rgb_in = 12'hF57;
    wait_hv(9, 1, "step_pos9");
    checks++;
    if (rgb_out !== 12'hF57) begin
      fails++; $display("FAIL step_h9: colour=%h, expected f57", rgb_out);
    end
    wait_hv(10, 1, "step_pos10");
    rgb_in = 12'hABC;
    #1;
    checks++;
    if (rgb_out !== exp10) begin
      fails++; $display("FAIL step_h10: colour=%h, expected %h", rgb_out, exp10);
    end
    wait_hv(11, 1, "step_pos11");
    checks++;
    if (rgb_out !== 12'hABC) begin
      fails++; $display("FAIL step_h11: colour=%h, expected abc", rgb_out);
    end
    rgb_in = 12'hF57;
  endtask

  task automatic test_hsync();
    int n = 0;
    wait_hv(655 + D, 1, "hs_pre");
    checks++;
    if (hsync !== 1'b1) begin
      fails++; $display("FAIL hs_before: hsync=%b at h=%0d, expected 1", hsync, h_cnt);
    end
    wait_hv(656 + D, 1, "hs_fall_pos");
    checks++;
    if (hsync !== 1'b0) begin
      fails++; $display("FAIL hs_fall: hsync=%b at h=%0d, expected 0", hsync, h_cnt);
    end
    while (hsync === 1'b0 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 384) begin
      fails++; $display("FAIL hs_width: low for %0d clk, expected 384", n);
    end
    checks++;
    if (h_cnt !== 10'(752 + D)) begin
      fails++; $display("FAIL hs_rise: rose at h=%0d, expected %0d", h_cnt, 752 + D);
    end
  endtask

  task automatic test_midreset();
    wait_hv(400, 300, "mid_pos");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (h_cnt !== 10'd0 || v_cnt !== 10'd0 || frame_start !== 1'b0 || pclk_en !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: h=%0d v=%0d fs=%b pclk=%b, expected 0 0 0 0",
               h_cnt, v_cnt, frame_start, pclk_en);
    end
  endtask

  task automatic test_rgb();
    rgb_in = 12'hF57;
    wait_hv(640 + D, 0, "rgb_pos_640_0");
    checks++;
    if (rgb_out !== 12'h000 || valid !== 1'b0) begin
      fails++; $display("FAIL rgb_640_0: colour=%h valid=%b, expected 000 0", rgb_out, valid);
    end
    wait_hv(639 + D, 479, "rgb_pos_639_479");
    checks++;
    if (vgaRed !== 4'hF || vgaGreen !== 4'h5 || vgaBlue !== 4'h7 || valid !== 1'b1) begin
      fails++; $display("FAIL rgb_639_479: colour=%h valid=%b, expected f57 1", rgb_out, valid);
    end
    wait_hv(D, 480, "rgb_pos_0_480");
    checks++;
    if (rgb_out !== 12'h000 || valid !== 1'b0) begin
      fails++; $display("FAIL rgb_0_480: colour=%h valid=%b, expected 000 0", rgb_out, valid);
    end
  endtask

  task automatic test_vsync();
    int n = 0;
    wait_hv(-1, 489, "vs_pre");
    checks++;
    if (vsync !== 1'b1) begin
      fails++; $display("FAIL vs_before: vsync=%b at v=489, expected 1", vsync);
    end
    wait_hv(D, 490, "vs_fall_pos");
    checks++;
    if (vsync !== 1'b0) begin
      fails++; $display("FAIL vs_fall: vsync=%b at v=490, expected 0", vsync);
    end
    while (vsync === 1'b0 && n < 10000) begin
      if (pclk_en) n++;
      @(negedge clk);
    end
    checks++;
    if (n != 1600) begin
      fails++; $display("FAIL vs_width: low for %0d pixels, expected 1600", n);
    end
    checks++;
    if (v_cnt !== 10'd492 || h_cnt !== 10'(D)) begin
      fails++; $display("FAIL vs_rise: rose at h=%0d v=%0d, expected %0d 492", h_cnt, v_cnt, D);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_rgb_step();
    test_hsync();
    test_midreset();
    test_rgb();
    test_vsync();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
